// File: rtl/dpsram_pipe.sv
// Single-clock true dual-port SRAM: byte enables, LAT-stage read pipeline, collision report.
// Define DPSRAM_PIPE_INIT_EN to add a post-reset clear sequence that zeroes every word.
module dpsram_pipe #(
    parameter int W        = 32,
    parameter int N        = 128,
    parameter int BW       = 8,
    parameter int LAT      = 1,
    parameter int RDW_MODE = 0,
    localparam int AW      = $clog2(N),
    localparam int B       = W / BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en0,
    input  logic          wen0,
    input  logic [B-1:0]  be0,
    input  logic [AW-1:0] addr0,
    input  logic [W-1:0]  din0,
    output logic [W-1:0]  dout0,
    output logic          dout0_vld,
    input  logic          en1,
    input  logic          wen1,
    input  logic [B-1:0]  be1,
    input  logic [AW-1:0] addr1,
    input  logic [W-1:0]  din1,
    output logic [W-1:0]  dout1,
    output logic          dout1_vld,
    output logic          col_vld,
    output logic [AW-1:0] col_addr,
    output logic          init_busy
);

    if ((W % BW) != 0 || LAT < 1 || LAT > 4 || N < 2) begin : g_param_check
        $fatal(1, "dpsram_pipe: illegal parameters W=%0d BW=%0d LAT=%0d N=%0d", W, BW, LAT, N);
    end

    logic [W-1:0]                mem_q [N];
    logic                        port_open;
    logic                        init_we;
    logic [AW-1:0]               init_addr;
    logic                        act0, act1, rd0, wr0, rd1, wr1;
    logic                        same_addr, ww;
    logic [W-1:0]                old0, old1, post0, post1;
    logic [1:0]                  vin;
    logic [1:0][W-1:0]           sin;
    logic [1:0][LAT-1:0]         vld_q, vld_d;
    logic [1:0][LAT-1:0][W-1:0]  dat_q, dat_d;
    logic                        col_vld_q, col_vld_d;
    logic [AW-1:0]               col_addr_q, col_addr_d;

`ifdef DPSRAM_PIPE_INIT_EN
    typedef enum logic [1:0] {INIT_IDLE, INIT_CLEAR, INIT_DONE} init_state_e;

    init_state_e   init_state_q, init_state_d;
    logic [AW-1:0] init_addr_q, init_addr_d;

    always_comb begin
        init_state_d = init_state_q;
        init_addr_d  = init_addr_q;
        case (init_state_q)
            INIT_IDLE: begin
                init_state_d = INIT_CLEAR;
                init_addr_d  = '0;
            end
            INIT_CLEAR: begin
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == AW'(N - 1)) begin
                    init_state_d = INIT_DONE;
                end
            end
            INIT_DONE: init_state_d = INIT_DONE;
            default:   init_state_d = INIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_state_q <= INIT_IDLE;
            init_addr_q  <= '0;
        end else begin
            init_state_q <= init_state_d;
            init_addr_q  <= init_addr_d;
        end
    end

    assign init_busy = (init_state_q == INIT_CLEAR);
    assign init_we   = init_busy & ~rst;
    assign init_addr = init_addr_q;
    assign port_open = (init_state_q == INIT_DONE);
`else
    assign init_busy = 1'b0;
    assign init_we   = 1'b0;
    assign init_addr = '0;
    assign port_open = 1'b1;
`endif

    // post0/post1 are the word as it will stand after this edge, including the
    // other port's lanes on a same-address write; port 0 owns contested lanes.
    always_comb begin
        act0      = en0 & ~rst & port_open;
        act1      = en1 & ~rst & port_open;
        rd0       = act0 & ~wen0;
        wr0       = act0 & wen0;
        rd1       = act1 & ~wen1;
        wr1       = act1 & wen1;
        same_addr = (addr0 == addr1);
        ww        = wr0 & wr1 & same_addr;
        old0      = mem_q[addr0];
        old1      = mem_q[addr1];
        post0     = old0;
        post1     = old1;
        for (int i = 0; i < B; i++) begin
            if (be0[i]) begin
                post0[i*BW +: BW] = din0[i*BW +: BW];
            end else if (ww && be1[i]) begin
                post0[i*BW +: BW] = din1[i*BW +: BW];
            end
            if (ww && be0[i]) begin
                post1[i*BW +: BW] = din0[i*BW +: BW];
            end else if (be1[i]) begin
                post1[i*BW +: BW] = din1[i*BW +: BW];
            end
        end
        vin[0]     = rd0 | (wr0 & (RDW_MODE != 0));
        vin[1]     = rd1 | (wr1 & (RDW_MODE != 0));
        sin[0]     = wr0 ? post0 : old0;
        sin[1]     = wr1 ? post1 : old1;
        col_vld_d  = act0 & act1 & same_addr & (wen0 | wen1);
        col_addr_d = col_vld_d ? addr0 : col_addr_q;
    end

    // Data stages only load alongside a valid token so dout holds between reads.
    always_comb begin
        vld_d = '0;
        dat_d = dat_q;
        for (int p = 0; p < 2; p++) begin
            vld_d[p][0] = vin[p];
            if (vin[p]) begin
                dat_d[p][0] = sin[p];
            end
            for (int s = 1; s < LAT; s++) begin
                vld_d[p][s] = vld_q[p][s-1];
                if (vld_q[p][s-1]) begin
                    dat_d[p][s] = dat_q[p][s-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            dat_q      <= '0;
            col_vld_q  <= 1'b0;
            col_addr_q <= '0;
        end else begin
            vld_q      <= vld_d;
            dat_q      <= dat_d;
            col_vld_q  <= col_vld_d;
            col_addr_q <= col_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_addr] <= '0;
        end
        if (wr1) begin
            mem_q[addr1] <= post1;
        end
        if (wr0) begin
            mem_q[addr0] <= post0;
        end
    end

    assign dout0     = dat_q[0][LAT-1];
    assign dout1     = dat_q[1][LAT-1];
    assign dout0_vld = vld_q[0][LAT-1];
    assign dout1_vld = vld_q[1][LAT-1];
    assign col_vld   = col_vld_q;
    assign col_addr  = col_addr_q;

endmodule

// File: tb/tb_dpsram_pipe.sv
// Directed bench for dpsram_pipe (W=32, N=16, LAT=2, RDW_MODE=0); covers the
// DPSRAM_PIPE_INIT_EN clear sequence when that macro is defined.
module tb_dpsram_pipe;

    localparam int W   = 32;
    localparam int N   = 16;
    localparam int BW  = 8;
    localparam int LAT = 2;
    localparam int AW  = 4;
    localparam int B   = 4;

`ifdef DPSRAM_PIPE_INIT_EN
    localparam logic [31:0] KEPT5 = 32'h0000_0000;
    localparam logic [31:0] KEPT3 = 32'h0000_0000;
`else
    localparam logic [31:0] KEPT5 = 32'hDEAD_BEEF;
    localparam logic [31:0] KEPT3 = 32'h11BB_33DD;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en0, wen0, en1, wen1;
    logic [B-1:0]  be0, be1;
    logic [AW-1:0] addr0, addr1;
    logic [W-1:0]  din0, din1;
    logic [W-1:0]  dout0, dout1;
    logic          dout0_vld, dout1_vld;
    logic          col_vld;
    logic [AW-1:0] col_addr;
    logic          init_busy;

    int total = 0;
    int bad   = 0;

    dpsram_pipe #(
        .W(W), .N(N), .BW(BW), .LAT(LAT), .RDW_MODE(0)
    ) dut (
        .clk(clk), .rst(rst),
        .en0(en0), .wen0(wen0), .be0(be0), .addr0(addr0), .din0(din0),
        .dout0(dout0), .dout0_vld(dout0_vld),
        .en1(en1), .wen1(wen1), .be1(be1), .addr1(addr1), .din1(din1),
        .dout1(dout1), .dout1_vld(dout1_vld),
        .col_vld(col_vld), .col_addr(col_addr), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive both ports, take one clock edge, and leave time 1ns past it for sampling.
    task automatic applyStimulus(input logic e0, input logic w0, input logic [3:0] b0,
                                 input logic [3:0] a0, input logic [31:0] d0,
                                 input logic e1, input logic w1, input logic [3:0] b1,
                                 input logic [3:0] a1, input logic [31:0] d1);
        en0 = e0; wen0 = w0; be0 = b0; addr0 = a0; din0 = d0;
        en1 = e1; wen1 = w1; be1 = b1; addr1 = a1; din1 = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic write0(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        applyStimulus(1'b1, 1'b1, b, a, d, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic write1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b1, b, a, d);
    endtask

    task automatic readCheck(input int port, input int a, input logic [31:0] exp, input string tag);
        if (port == 0) begin
            applyStimulus(1'b1, 1'b0, 4'h0, 4'(a), 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        end else begin
            applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
        end
        checkOutput({tag, "_early"}, (port == 0) ? dout0_vld : dout1_vld, 32'd0);
        idle();
        checkOutput({tag, "_vld"}, (port == 0) ? dout0_vld : dout1_vld, 32'd1);
        checkOutput({tag, "_data"}, (port == 0) ? dout0 : dout1, exp);
        idle();
        checkOutput({tag, "_drop"}, (port == 0) ? dout0_vld : dout1_vld, 32'd0);
        checkOutput({tag, "_hold"}, (port == 0) ? dout0 : dout1, exp);
    endtask

    // Called one edge after reset release.
    task automatic waitInit();
`ifdef DPSRAM_PIPE_INIT_EN
        int   cnt    = 0;
        logic sawVld = 1'b0;
        for (int i = 0; i < N + 8; i++) begin
            if (!init_busy) break;
            cnt++;
            if (dout0_vld) sawVld = 1'b1;
            applyStimulus(1'b1, 1'b0, 4'h0, 4'(i % N), 32'h0, 1'b1, 1'b1, 4'hF, 4'(i % N), 32'hFFFF_FFFF);
            if (col_vld) sawVld = 1'b1;
        end
        idle();
        if (dout0_vld) sawVld = 1'b1;
        idle();
        if (dout0_vld) sawVld = 1'b1;
        checkOutput("init_cycles", cnt, N);
        checkOutput("init_ignored", {31'd0, sawVld}, 32'd0);
`else
        checkOutput("init_busy_off", {31'd0, init_busy}, 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle();
        idle();
        idle();
        checkOutput("rst_dout0", dout0, 32'h0);
        checkOutput("rst_dout1", dout1, 32'h0);
        checkOutput("rst_vld0", {31'd0, dout0_vld}, 32'd0);
        checkOutput("rst_vld1", {31'd0, dout1_vld}, 32'd0);
        checkOutput("rst_col_vld", {31'd0, col_vld}, 32'd0);
        checkOutput("rst_col_addr", {28'd0, col_addr}, 32'd0);
        checkOutput("rst_init_busy", {31'd0, init_busy}, 32'd0);
        rst = 1'b0;
        idle();
        waitInit();

        write0(4'd5, 32'hDEAD_BEEF, 4'hF);
        checkOutput("wr_novld_now", {31'd0, dout0_vld}, 32'd0);
        idle();
        checkOutput("wr_novld_lat", {31'd0, dout0_vld}, 32'd0);
        readCheck(0, 5, 32'hDEAD_BEEF, "rd5");

        write0(4'd3, 32'h1122_3344, 4'hF);
        write0(4'd3, 32'hAABB_CCDD, 4'b0101);
        readCheck(1, 3, 32'h11BB_33DD, "be_merge");

        applyStimulus(1'b1, 1'b1, 4'b1100, 4'd7, 32'hFFFF_0000, 1'b1, 1'b1, 4'b1111, 4'd7, 32'h0000_FFFF);
        checkOutput("ww_col_vld", {31'd0, col_vld}, 32'd1);
        checkOutput("ww_col_addr", {28'd0, col_addr}, 32'd7);
        idle();
        checkOutput("ww_col_clear", {31'd0, col_vld}, 32'd0);
        readCheck(0, 7, 32'hFFFF_FFFF, "ww_merge");

        applyStimulus(1'b1, 1'b1, 4'hF, 4'd8, 32'h1234_5678, 1'b1, 1'b1, 4'hF, 4'd8, 32'hAAAA_AAAA);
        checkOutput("ww8_col_addr", {28'd0, col_addr}, 32'd8);
        idle();
        readCheck(1, 8, 32'h1234_5678, "ww_p0wins");

        write1(4'd9, 32'h0000_0001, 4'hF);
        checkOutput("single_no_col", {31'd0, col_vld}, 32'd0);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd9, 32'h0000_0002, 1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
        checkOutput("rw_col_vld", {31'd0, col_vld}, 32'd1);
        checkOutput("rw_col_addr", {28'd0, col_addr}, 32'd9);
        checkOutput("rw_early", {31'd0, dout1_vld}, 32'd0);
        idle();
        checkOutput("rw_vld", {31'd0, dout1_vld}, 32'd1);
        checkOutput("rw_old_data", dout1, 32'h0000_0001);
        checkOutput("rw_col_once", {31'd0, col_vld}, 32'd0);
        idle();
        readCheck(0, 9, 32'h0000_0002, "rw_new");

        applyStimulus(1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        checkOutput("rr_no_col", {31'd0, col_vld}, 32'd0);
        idle();
        checkOutput("rr_vld0", {31'd0, dout0_vld}, 32'd1);
        checkOutput("rr_dout0", dout0, 32'hDEAD_BEEF);
        checkOutput("rr_vld1", {31'd0, dout1_vld}, 32'd1);
        checkOutput("rr_dout1", dout1, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd10, 32'hCAFE_0001, 1'b1, 1'b1, 4'hF, 4'd11, 32'hCAFE_0002);
        checkOutput("diff_no_col", {31'd0, col_vld}, 32'd0);
        idle();
        readCheck(0, 10, 32'hCAFE_0001, "diff_a10");
        readCheck(1, 11, 32'hCAFE_0002, "diff_a11");

        applyStimulus(1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b1, 1'b1, 4'h0, 4'd3, 32'hFFFF_FFFF);
        checkOutput("pre_rst_vld0", {31'd0, dout0_vld}, 32'd1);
        checkOutput("pre_rst_dout0", dout0, 32'hDEAD_BEEF);
        checkOutput("pre_rst_col", {31'd0, col_vld}, 32'd1);
        checkOutput("pre_rst_col_addr", {28'd0, col_addr}, 32'd3);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd5, 32'h5555_5555, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        checkOutput("mid_rst_vld0", {31'd0, dout0_vld}, 32'd0);
        checkOutput("mid_rst_dout0", dout0, 32'h0);
        checkOutput("mid_rst_vld1", {31'd0, dout1_vld}, 32'd0);
        checkOutput("mid_rst_dout1", dout1, 32'h0);
        checkOutput("mid_rst_col", {31'd0, col_vld}, 32'd0);
        checkOutput("mid_rst_col_addr", {28'd0, col_addr}, 32'd0);
        rst = 1'b0;
        idle();
        checkOutput("post_rst_vld0", {31'd0, dout0_vld}, 32'd0);
        checkOutput("post_rst_vld1", {31'd0, dout1_vld}, 32'd0);
        waitInit();
        readCheck(0, 5, KEPT5, "rst_wr_ignored");
        readCheck(1, 3, KEPT3, "rst_mem_kept");

`ifdef DPSRAM_PIPE_INIT_EN
        for (int a = 0; a < N; a++) begin
            readCheck(a % 2, a, 32'h0, "init_zero");
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpsram_pipe.md
Name: dpsram_pipe

Overview:
Single-clock true dual-port SRAM. Adds byte-write enables, a configurable read pipeline latency with per-port valid strobes, a defined collision policy, and a collision report interface. Used as the generic storage primitive under libv FIFOs, caches and register files where both ports share one clock domain.

Parameters:
W, 32, word width in bits; must be a multiple of BW.
N, 128, depth in words; N >= 2. Address width is $clog2(N).
BW, 8, byte-enable granularity in bits. Byte-enable width is B = W/BW.
LAT, 1, read latency in cycles, legal range 1..4.
RDW_MODE, 0, same-port write read-back: 0 = write produces no read data; 1 = write-through, the written word is returned on dout.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
en0  in  1  port 0 access enable
wen0  in  1  port 0 write (1) / read (0)
be0  in  B  port 0 byte enables; writes only
addr0  in  $clog2(N)  port 0 address
din0  in  W  port 0 write data
dout0  out  W  port 0 read data
dout0_vld  out  1  port 0 read data valid
en1, wen1, be1, addr1, din1, dout1, dout1_vld  as port 0, for port 1
col_vld  out  1  collision detected this cycle (registered)
col_addr  out  $clog2(N)  address of the reported collision
init_busy  out  1  initialisation in progress (see Optional Feature)

Behaviour:
- Single clock, synchronous active-high reset; one clock edge `clk` for all state.
- Reset values: dout0/dout1 = 0, dout*_vld = 0, col_vld = 0, col_addr = 0, all read pipeline stages flushed. Memory array is not reset.
- Read: en & ~wen accepted at edge t. The word at addr (value before any same-cycle write) appears on dout with vld = 1 after edge t+LAT-1, i.e. visible for exactly one cycle LAT cycles after issue.
- Reads are fully pipelined: one read per port per cycle, no stalls.
- dout holds its last value when vld = 0.
- Write: en & wen writes byte lanes i where be[i] = 1; other lanes keep their value. A write with be = 0 is a legal no-op.
- RDW_MODE = 1: a write also returns the merged post-write word on dout with vld at the same latency as a read. RDW_MODE = 0: a write never asserts vld.
- Collision: en0 & en1 & (addr0 == addr1) & (wen0 | wen1). On collision, col_vld = 1 and col_addr = addr0 on the next cycle; otherwise col_vld = 0.
- Write/write collision: port 0 wins on lanes where be0 = 1. Port 1 lanes with be1 = 1 & be0 = 0 are still written.
- Read/write collision across ports: the reader gets old data (read-first). The write completes normally.
- Reset mid-operation: all in-flight reads are discarded and no vld is asserted for them. A write on the reset cycle is ignored. Memory contents are otherwise preserved.
- Illegal parameters (W % BW != 0, LAT outside 1..4) trigger an elaboration-time $fatal.

Optional Feature:
Macro DPSRAM_PIPE_INIT_EN.
- Defined: on the cycle after rst deasserts, an init FSM (IDLE -> CLEAR -> DONE) writes 0 to addresses 0..N-1 ascending, one per cycle. init_busy = 1 for exactly N cycles.
- During init, en0/en1 are ignored: no writes, no vld, no col_vld.
- Reasserting rst during CLEAR restarts the sequence from address 0 once rst falls.
- Not defined: no FSM, init_busy tied 0, memory contents undefined after power-up.

Test Plan:
- W=32, LAT=2: write addr 5 = 0xDEADBEEF, read addr 5 at cycle t -> dout0 = 0xDEADBEEF with dout0_vld high only in cycle t+2.
- Write addr 3 = 0x11223344, then write 0xAABBCCDD with be0 = 4'b0101 -> read returns 0x11BB33DD.
- Same cycle, port 0 writes addr 7 = 0xFFFF0000 with be0 = 4'b1100; port 1 writes addr 7 = 0x0000FFFF with be1 = 4'b1111 -> memory 0xFFFFFFFF; col_vld = 1 and col_addr = 7 next cycle.
- Addr 9 holds 0x1. Port 0 writes 0x2 while port 1 reads addr 9 -> dout1 = 0x1 after LAT; a later read returns 0x2; col_vld pulses once.
- LAT=3, issue reads on cycles 0, 1 and 2, assert rst on cycle 3 -> no vld in cycles 3..5; all outputs 0 during reset.
- DPSRAM_PIPE_INIT_EN defined, N=16: release rst -> init_busy high for 16 cycles, en0 reads ignored meanwhile; afterwards reads of addr 0..15 all return 0.
